// File: rtl/fifo_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkt_reader
// Description : Drains a show-ahead FIFO in fixed-size packets onto a
//               valid/ready stream. A burst starts when a full packet is
//               available, or when flush_i asks for the partial packet
//               currently held. The output side is a two-entry buffer
//               (output register + skid register), so the stream outputs
//               are registered and full throughput is kept under
//               back-pressure.
// Ports       : clk_i / rst_i            clock, async active-high reset
//               fifo_rd_data_i           FIFO show-ahead data
//               fifo_empty_i             FIFO empty flag
//               fifo_used_words_i        FIFO occupancy (ADDR_WIDTH+1 bits)
//               fifo_rd_o                FIFO pop strobe (combinational)
//               flush_i                  emit current partial packet
//               tdata_o/tvalid_o/tlast_o stream outputs
//               tready_i                 stream ready
//               busy_o                   high while a burst is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pkt_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int PKT_WORDS  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    input  logic [ADDR_WIDTH:0]   fifo_used_words_i,
    output logic                  fifo_rd_o,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    output logic                  tlast_o,
    input  logic                  tready_i,
    output logic                  busy_o
);

    localparam int                  c_cnt_w    = $clog2(PKT_WORDS + 1);
    localparam logic [c_cnt_w-1:0]  c_one      = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_pkt_left = c_cnt_w'(PKT_WORDS);
    localparam logic [ADDR_WIDTH:0] c_pkt_used = (ADDR_WIDTH + 1)'(PKT_WORDS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_q,   state_d;
    logic [c_cnt_w-1:0]    rd_left_q, rd_left_d;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    // Buffer entries are {tlast, data}; out_q is always the oldest entry.
    logic [DATA_WIDTH:0]   out_q,     out_d;
    logic [DATA_WIDTH:0]   skid_q,    skid_d;

    logic                  w_fifo_rd;
    logic                  w_beat;
    logic [DATA_WIDTH:0]   w_new;

    always_comb begin
        // Pop only when there is room in the buffer; this is what keeps
        // words from being lost when the stream stalls.
        w_fifo_rd = (state_q == BURST) && (rd_left_q != '0) &&
                    !fifo_empty_i && (buf_cnt_q != 2'd2);
        w_beat    = (buf_cnt_q != 2'd0) && tready_i;
        w_new     = {(rd_left_q == c_one), fifo_rd_data_i};

        state_d   = state_q;
        rd_left_d = rd_left_q;
        case (state_q)
            IDLE: begin
                if (fifo_used_words_i >= c_pkt_used) begin
                    state_d   = BURST;
                    rd_left_d = c_pkt_left;
                end else if (flush_i && !fifo_empty_i) begin
                    // Occupancy is below PKT_WORDS here, so it fits the counter.
                    state_d   = BURST;
                    rd_left_d = c_cnt_w'(fifo_used_words_i);
                end
            end
            BURST: begin
                if (rd_left_q == '0) begin
                    // Only reachable if the FIFO flags disagree; recover.
                    state_d = IDLE;
                end else if (w_fifo_rd) begin
                    rd_left_d = rd_left_q - c_one;
                    if (rd_left_q == c_one) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_d     = out_q;
        skid_d    = skid_q;
        buf_cnt_d = buf_cnt_q;
        case (buf_cnt_q)
            2'd0: begin
                if (w_fifo_rd) begin
                    out_d     = w_new;
                    buf_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (w_fifo_rd && w_beat) begin
                    out_d = w_new;
                end else if (w_beat) begin
                    buf_cnt_d = 2'd0;
                end else if (w_fifo_rd) begin
                    skid_d    = w_new;
                    buf_cnt_d = 2'd2;
                end
            end
            2'd2: begin
                // No pop is possible when full, so only a beat moves data.
                if (w_beat) begin
                    out_d     = skid_q;
                    buf_cnt_d = 2'd1;
                end
            end
            default: buf_cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rd_left_q <= '0;
            buf_cnt_q <= 2'd0;
            out_q     <= '0;
            skid_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_left_q <= rd_left_d;
            buf_cnt_q <= buf_cnt_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
        end
    end

    assign fifo_rd_o = w_fifo_rd;
    assign tvalid_o  = (buf_cnt_q != 2'd0);
    assign tdata_o   = out_q[DATA_WIDTH-1:0];
    assign tlast_o   = out_q[DATA_WIDTH];
    assign busy_o    = (state_q == BURST);

endmodule
`default_nettype wire
